// File: rtl/seq_det_pkg.sv
`default_nettype none
// seq_det_pkg: ASCII symbol constants, wildcard symbol and detector state encoding. Rev 1.0
package seq_det_pkg;

  localparam logic [7:0] CH_A = 8'h41, CH_B = 8'h42, CH_C = 8'h43, CH_D = 8'h44,
                         CH_E = 8'h45, CH_F = 8'h46, CH_G = 8'h47, CH_H = 8'h48,
                         CH_I = 8'h49, CH_J = 8'h4A, CH_K = 8'h4B, CH_L = 8'h4C,
                         CH_M = 8'h4D, CH_N = 8'h4E, CH_O = 8'h4F, CH_P = 8'h50,
                         CH_Q = 8'h51, CH_R = 8'h52, CH_S = 8'h53, CH_T = 8'h54,
                         CH_U = 8'h55, CH_V = 8'h56, CH_W = 8'h57, CH_X = 8'h58,
                         CH_Y = 8'h59, CH_Z = 8'h5A;

  localparam logic [7:0] WILDCARD = 8'hFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_det_hist.sv
`default_nettype none
// seq_det_hist: symbol shift history (newest at slot 0) with flush and fill counter saturating at len. Rev 1.0
module seq_det_hist #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            shift,
  input  logic                            fill_clr,
  input  logic [SYM_W-1:0]                din,
  input  logic [LEN_W-1:0]                len,
  output logic [MAX_LEN-1:0][SYM_W-1:0]   hist_n,
  output logic [LEN_W-1:0]                fill_n
);

  logic [MAX_LEN-1:0][SYM_W-1:0] hist;
  logic [LEN_W-1:0]              fill;

  // Next-state view is exported so the match can be judged on the symbol being accepted.
  always_comb begin
    hist_n = hist;
    fill_n = fill;
    if (shift) begin
      hist_n[0] = din;
      for (int k = 1; k < MAX_LEN; k++) hist_n[k] = hist[k-1];
      fill_n = (fill >= len) ? len : fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (flush) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_n;
      fill <= fill_clr ? '0 : fill_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// seq_det_prog: runtime-programmable sequence detector with match pulse and saturating counter. Rev 1.0
// Define SEQ_DET_WILDCARD_EN to make an all-ones pattern slot match any symbol.
module seq_det_prog import seq_det_pkg::*; #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [SYM_W-1:0] din,
  input  logic             cfg_wr,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic             cfg_commit,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             armed,
  output logic             eureka,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
`ifdef SEQ_DET_WILDCARD_EN
  localparam logic [SYM_W-1:0] WILD = '1;
`endif

  seq_state_t                    state, state_n;
  logic [MAX_LEN-1:0][SYM_W-1:0] pat;
  logic [MAX_LEN-1:0][SYM_W-1:0] hist_n;
  logic [LEN_W-1:0]              fill_n, len_q;
  logic                          ovl_q, flush, shift, err_n, len_ok, hit;
  logic [IDX_W-1:0]              ri;

  function automatic logic sym_eq(input logic [SYM_W-1:0] p, input logic [SYM_W-1:0] h);
`ifdef SEQ_DET_WILDCARD_EN
    return (p == WILD) || (p == h);
`else
    return p == h;
`endif
  endfunction

  assign len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign armed  = (state == ARMED);

  // Config traffic takes priority over the stream; a stray symbol in that cycle is dropped.
  always_comb begin
    state_n = state;
    flush   = 1'b0;
    shift   = 1'b0;
    err_n   = 1'b0;
    if (cfg_commit) begin
      flush = 1'b1;
      if (len_ok) begin
        state_n = ARMED;
      end else begin
        state_n = IDLE;
        err_n   = 1'b1;
      end
    end else if (cfg_wr) begin
      flush   = 1'b1;
      state_n = IDLE;
    end else if (state == ARMED && din_valid) begin
      shift = 1'b1;
    end
  end

  // Oldest stored symbol pairs with slot 0 of the pattern.
  always_comb begin
    hit = shift && (fill_n == len_q);
    ri  = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(len_q)) begin
        ri = IDX_W'(int'(len_q) - 1 - k);
        if (!sym_eq(pat[ri], hist_n[k])) hit = 1'b0;
      end
    end
  end

  seq_det_hist #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .shift    (shift),
    .fill_clr (hit && !ovl_q),
    .din      (din),
    .len      (len_q),
    .hist_n   (hist_n),
    .fill_n   (fill_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pat       <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      eureka    <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
    end else begin
      state   <= state_n;
      eureka  <= hit;
      cfg_err <= err_n;
      if (cfg_wr && (int'(cfg_idx) < MAX_LEN)) pat[cfg_idx] <= cfg_sym;
      if (cfg_commit && len_ok) begin
        len_q <= cfg_len;
        ovl_q <= cfg_ovl;
      end
      if (cnt_clr)                       match_cnt <= '0;
      else if (hit && match_cnt != '1)   match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// tb_seq_det_prog: directed self-checking bench for seq_det_prog (CNT_W=2 instance).
module tb_seq_det_prog;
  import seq_det_pkg::*;

  localparam int CNT_W = 2;

  logic             clk = 1'b0, rst = 1'b1;
  logic             din_valid = 1'b0, cfg_wr = 1'b0, cfg_commit = 1'b0, cfg_ovl = 1'b0, cnt_clr = 1'b0;
  logic [7:0]       din = '0, cfg_sym = '0;
  logic [2:0]       cfg_idx = '0;
  logic [3:0]       cfg_len = '0;
  logic             armed, eureka, cfg_err;
  logic [CNT_W-1:0] match_cnt;
  int               n_checks = 0, n_fail = 0;
  logic [31:0]      m, gm, exp_cnt, exp_wild;

  always #5 clk = ~clk;

  seq_det_prog #(.SYM_W(8), .MAX_LEN(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .cfg_commit(cfg_commit), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .armed(armed), .eureka(eureka),
    .cfg_err(cfg_err), .match_cnt(match_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [7:0] sym);
    cfg_wr = 1'b1; cfg_idx = idx[2:0]; cfg_sym = sym;
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic commit(input int len, input logic ovl);
    cfg_commit = 1'b1; cfg_len = len[3:0]; cfg_ovl = ovl;
    cyc();
    cfg_commit = 1'b0;
  endtask

  task automatic load(input string s, input logic ovl);
    for (int i = 0; i < s.len(); i++) wr(i, s[i]);
    commit(s.len(), ovl);
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
  endtask

  // hm bit i: eureka seen right after symbol i; gmask bit i: eureka seen in the idle gap after it.
  task automatic send_str(input string s, input int gap, output logic [31:0] hm, output logic [31:0] gmask);
    hm = '0;
    gmask = '0;
    for (int i = 0; i < s.len(); i++) begin
      din_valid = 1'b1; din = s[i];
      cyc();
      if (eureka) hm[i] = 1'b1;
      din_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        cyc();
        if (eureka) gmask[i] = 1'b1;
      end
    end
    din_valid = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("rst_armed", armed, 0);
    check("rst_eureka", eureka, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cnt", match_cnt, 0);

    load("HOMEWORK", 1'b1);
    check("hw_armed", armed, 1);
    send_str("XHOMEWORKH", 0, m, gm);
    check("hw_hits", m, 32'h100);
    check("hw_cnt", match_cnt, 1);

    load("RARA", 1'b1);
    send_str("RARARA", 0, m, gm);
    check("rara_ovl", m, 32'h28);
    commit(4, 1'b0);
    send_str("RARARA", 0, m, gm);
    check("rara_novl", m, 32'h08);

    load("HOMEWORK", 1'b0);
    send_str("HHOMEWORK", 1, m, gm);
    check("gap_hits", m, 32'h100);
    check("gap_pulse", gm, 32'h0);

    commit(0, 1'b1);
    check("len0_err", cfg_err, 1);
    check("len0_armed", armed, 0);
    cyc();
    check("err_pulse", cfg_err, 0);
    commit(9, 1'b1);
    check("len9_err", cfg_err, 1);
    load("RARA", 1'b1);
    wr(0, CH_R);
    check("wr_disarm", armed, 0);
    send_str("RARA", 0, m, gm);
    check("wr_nohit", m, 32'h0);
    commit(4, 1'b1);
    send_str("RARA", 0, m, gm);
    check("recommit", m, 32'h08);

    cfg_wr = 1'b1; cfg_idx = 3'd3; cfg_sym = CH_E;
    cfg_commit = 1'b1; cfg_len = 4'd4; cfg_ovl = 1'b1;
    din_valid = 1'b1; din = CH_R;
    cyc();
    cfg_wr = 1'b0; cfg_commit = 1'b0; din_valid = 1'b0;
    check("wrc_armed", armed, 1);
    send_str("RARERARA", 0, m, gm);
    check("wrc_hits", m, 32'h08);

    load("A", 1'b1);
    clr_cnt();
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1; din = CH_A;
      cyc();
      exp_cnt = (i + 1 > 3) ? 32'd3 : 32'(i + 1);
      check($sformatf("sat_cnt%0d", i), match_cnt, exp_cnt);
    end
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0; din_valid = 1'b0;
    check("clr_wins", match_cnt, 0);
    check("clr_hit", eureka, 1);

    load("HOMEWORK", 1'b1);
    send_str("HOMEWORK", 0, m, gm);
    check("pre_rst_cnt", match_cnt, 1);
    send_str("HOMEW", 0, m, gm);
    rst = 1'b1;
    #1;
    check("arst_armed", armed, 0);
    check("arst_cnt", match_cnt, 0);
    check("arst_err", cfg_err, 0);
    cyc();
    rst = 1'b0;
    load("HOMEWORK", 1'b1);
    send_str("ORK", 0, m, gm);
    check("post_rst", m, 32'h0);

    wr(0, CH_R); wr(1, WILDCARD); wr(2, CH_R); wr(3, CH_A);
    commit(4, 1'b1);
    send_str("RXRA", 0, m, gm);
`ifdef SEQ_DET_WILDCARD_EN
    exp_wild = 32'h08;
`else
    exp_wild = 32'h0;
`endif
    check("wildcard", m, exp_wild);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
